two_to_one_merge_16bit: RTL and testbench
=========================================

# two_to_one_merge_16bit

Registered 2:1 stream merger that recombines the two lanes produced by the 16-bit 1:2 demultiplexer into one stream for the downstream CNN datapath. Two valid/ready input lanes are arbitrated round-robin, one word per cycle is registered into a single output stage, and each word is tagged with its source lane. Per-lane forwarded-word counters support bring-up and debug.

## Interface
- BITS, 16, data width of both input lanes and the output
- CNT_BITS, 16, width of the saturating status counters
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in1_data  input  BITS  lane 1 word (select value 0 on the demux side)
- in1_valid  input  1  lane 1 word present
- in1_ready  output  1  lane 1 word accepted this cycle when high with in1_valid
- in2_data  input  BITS  lane 2 word (select value 1)
- in2_valid  input  1  lane 2 word present
- in2_ready  output  1  lane 2 accept
- out_data  output  BITS  merged word
- out_sel  output  1  source tag of out_data: 0 = lane 1, 1 = lane 2
- out_valid  output  1  out_data/out_sel valid
- out_ready  input  1  downstream accepts when high with out_valid
- cnt1  output  CNT_BITS  words forwarded from lane 1, saturating
- cnt2  output  CNT_BITS  words forwarded from lane 2, saturating
- skip_cnt  output  CNT_BITS  zero words dropped, saturating (see Configuration)

## Operation
- Output stage states: EMPTY (out_valid=0), FULL (out_valid=1).
- load_ok = !out_valid | out_ready (combinational; output stage free or draining this cycle).
- Grant: only lane 1 valid -> lane 1; only lane 2 valid -> lane 2; both valid -> lane not in last_grant; none -> no grant.
- inN_ready = load_ok & grant==N. At most one of in1_ready/in2_ready is high in a cycle; the other lane holds.
- Accept (inN_valid & inN_ready) at clk edge: out_data<=inN_data, out_sel<=N-1, out_valid<=1, last_grant<=N, cntN<=cntN+1 unless at all-ones.
- Drain without accept (out_valid & out_ready, no grant): out_valid<=0; out_data/out_sel hold their last value.
- Simultaneous drain and accept: new word replaces old in the same edge; out_valid stays 1; no bubble.
- out_valid & !out_ready: output held stable, both readys low, last_grant unchanged.
- Counters saturate at 2^CNT_BITS-1; never wrap.
- No data transformation; BITS-wide words pass unchanged (except zero-skip).

## Timing
- Reset (async assert, sync release on next edge): out_valid=0, out_data=0, out_sel=0, last_grant=lane 2 (lane 1 wins first contention), cnt1=cnt2=skip_cnt=0; readys evaluate combinationally (high once inputs valid since stage is EMPTY).
- Latency: input accept edge -> out_valid high after that edge (1 cycle).
- Throughput: 1 word/cycle sustained with out_ready held high; both lanes valid -> strict alternation 1,2,1,2...
- inN_ready depends combinationally on out_ready; out_* are registered.
- Reset mid-transfer: held output word discarded, out_valid falls immediately (async), arbitration restarts with lane 1 priority.

## Configuration
- ZERO_SKIP_EN defined: an accepted word equal to 0 completes the input handshake and updates last_grant, but is not loaded; out_valid/out_data/out_sel behave as for a cycle with no accept (drain still applies); cntN not incremented; skip_cnt increments (saturating).
- ZERO_SKIP_EN undefined: zero words forwarded like any other; skip_cnt held at 0.

## Test plan
- Reset, then lane 1 sends 0x1234 only, out_ready=1 -> next cycle out_data=0x1234, out_sel=0, out_valid=1, cnt1=1.
- Both lanes valid continuously (lane1 0x00A1.., lane2 0x00B1..), out_ready=1 -> outputs alternate sel 0,1,0,1 starting with lane 1, one word per cycle, no bubbles.
- out_ready low 3 cycles with FULL stage -> out_data stable, in1_ready=in2_ready=0, resumes with correct round-robin lane after release.
- Drive cnt1 to 0xFFFF and forward one more lane-1 word -> cnt1 stays 0xFFFF.
- Lane 2 sends 0x0000 then 0x0055: with ZERO_SKIP_EN only 0x0055 appears (sel=1), skip_cnt=1, cnt2=1; without it both appear, skip_cnt=0, cnt2=2.
- Assert reset while out_valid=1 and out_ready=0 -> out_valid drops asynchronously, counters 0, first post-reset contention granted to lane 1.

Source files
------------

// File: rtl/two_to_one_merge_16bit.sv
// Registered 2:1 round-robin stream merger with source tagging and per-lane status counters.
// Optional build macro ZERO_SKIP_EN: accepted all-zero words are consumed but not forwarded.
module two_to_one_merge_16bit #(
   parameter int BITS     = 16,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [BITS-1:0]     in1_data,
   input  logic                in1_valid,
   output logic                in1_ready,
   input  logic [BITS-1:0]     in2_data,
   input  logic                in2_valid,
   output logic                in2_ready,
   output logic [BITS-1:0]     out_data,
   output logic                out_sel,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CNT_BITS-1:0] cnt1,
   output logic [CNT_BITS-1:0] cnt2,
   output logic [CNT_BITS-1:0] skip_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t              state_reg;
   logic [BITS-1:0]     out_data_reg;
   logic                out_sel_reg;
   logic                last_grant_reg;   // 0: lane 1 won last, 1: lane 2 won last
   logic [CNT_BITS-1:0] cnt1_reg;
   logic [CNT_BITS-1:0] cnt2_reg;

   logic            load_ok;
   logic            grant1;
   logic            grant2;
   logic            acc1;
   logic            acc2;
   logic            accept;
   logic [BITS-1:0] acc_data;
   logic            skip;
   logic            load_word;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign out_valid = (state_reg == FULL);
   assign out_data  = out_data_reg;
   assign out_sel   = out_sel_reg;
   assign cnt1      = cnt1_reg;
   assign cnt2      = cnt2_reg;

   // Under contention the lane that did not win last time gets the slot.
   always_comb begin
      load_ok   = !out_valid || out_ready;
      grant1    = in1_valid && (!in2_valid || last_grant_reg);
      grant2    = in2_valid && (!in1_valid || !last_grant_reg);
      in1_ready = load_ok && grant1;
      in2_ready = load_ok && grant2;
      acc1      = in1_valid && in1_ready;
      acc2      = in2_valid && in2_ready;
      accept    = acc1 || acc2;
      acc_data  = acc2 ? in2_data : in1_data;
   end

`ifdef ZERO_SKIP_EN
   logic [CNT_BITS-1:0] skip_cnt_reg;

   assign skip     = accept && (acc_data == '0);
   assign skip_cnt = skip_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skip_cnt_reg <= '0;
      end else if (skip) begin
         skip_cnt_reg <= sat_inc(skip_cnt_reg);
      end
   end
`else
   assign skip     = 1'b0;
   assign skip_cnt = '0;
`endif

   assign load_word = accept && !skip;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= EMPTY;
         out_data_reg   <= '0;
         out_sel_reg    <= 1'b0;
         last_grant_reg <= 1'b1;
         cnt1_reg       <= '0;
         cnt2_reg       <= '0;
      end else begin
         if (accept) begin
            last_grant_reg <= acc2;
         end
         // A skipped word leaves the stage as if nothing arrived, so drain still applies.
         case (state_reg)
            EMPTY: begin
               if (load_word) begin
                  state_reg    <= FULL;
                  out_data_reg <= acc_data;
                  out_sel_reg  <= acc2;
               end
            end
            FULL: begin
               if (load_word) begin
                  out_data_reg <= acc_data;
                  out_sel_reg  <= acc2;
               end else if (out_ready) begin
                  state_reg <= EMPTY;
               end
            end
            default: state_reg <= EMPTY;
         endcase
         if (acc1 && !skip) begin
            cnt1_reg <= sat_inc(cnt1_reg);
         end
         if (acc2 && !skip) begin
            cnt2_reg <= sat_inc(cnt2_reg);
         end
      end
   end

endmodule

// File: tb/tb_two_to_one_merge_16bit.sv
// Scoreboard bench for two_to_one_merge_16bit: lane drivers feed queues, a monitor checks merged output order.
module tb_two_to_one_merge_16bit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in1_data, in2_data;
   logic        in1_valid, in2_valid;
   logic        in1_ready, in2_ready;
   logic [15:0] out_data;
   logic        out_sel, out_valid;
   logic        out_ready;
   logic [15:0] cnt1, cnt2, skip_cnt;

   two_to_one_merge_16bit dut (
      .clk       (clk),
      .reset     (reset),
      .in1_data  (in1_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in2_data  (in2_data),
      .in2_valid (in2_valid),
      .in2_ready (in2_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .skip_cnt  (skip_cnt)
   );

   always #5 clk = ~clk;

   logic [16:0] exp_q[$];   // {sel, data}
   logic [15:0] l1_q[$];
   logic [15:0] l2_q[$];
   int          out_cyc[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   bit          verbose = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) begin
         n_pass++;
         if (verbose) $display("ok   %-12s actual=%h required=%h", name, act, req);
      end else begin
         $display("FAIL %-12s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic flush();
      exp_q.delete();
      l1_q.delete();
      l2_q.delete();
   endtask

   task automatic reset_dut();
      tick();
      reset = 1'b1;
      flush();
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || l1_q.size() != 0 || l2_q.size() != 0 ||
              in1_valid || in2_valid) && n < bound) begin
         tick();
         n++;
      end
      chk(name, exp_q.size(), 0);
      tick();
   endtask

   // Lane drivers: present the queue head and hold it until handshaken.
   initial begin
      bit acc;
      in1_valid = 1'b0;
      in1_data  = '0;
      forever begin
         @(negedge clk);
         acc = in1_valid && in1_ready && !reset;
         @(posedge clk);
         #1;
         if (acc && l1_q.size() > 0) void'(l1_q.pop_front());
         if (!reset && l1_q.size() > 0) begin
            in1_valid = 1'b1;
            in1_data  = l1_q[0];
         end else begin
            in1_valid = 1'b0;
         end
      end
   end

   initial begin
      bit acc;
      in2_valid = 1'b0;
      in2_data  = '0;
      forever begin
         @(negedge clk);
         acc = in2_valid && in2_ready && !reset;
         @(posedge clk);
         #1;
         if (acc && l2_q.size() > 0) void'(l2_q.pop_front());
         if (!reset && l2_q.size() > 0) begin
            in2_valid = 1'b1;
            in2_data  = l2_q[0];
         end else begin
            in2_valid = 1'b0;
         end
      end
   end

   // Monitor: every output handshake must match the scoreboard head.
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready && !reset) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL out_unexp   actual=%h required=none", {out_sel, out_data});
            end else begin
               e = exp_q.pop_front();
               chk("out_word", {15'd0, out_sel, out_data}, {15'd0, e});
            end
         end
      end
   end

   initial begin
      int n;
      reset     = 1'b1;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sel", out_sel, 0);
      chk("rst_cnts", {cnt1, cnt2}, 0);
      chk("rst_skip", skip_cnt, 0);
      reset = 1'b0;

      // Single lane-1 word, 1-cycle latency.
      out_ready = 1'b1;
      l1_q.push_back(16'h1234);
      exp_q.push_back({1'b0, 16'h1234});
      tick();
      chk("lat_pre", out_valid, 0);
      tick();
      chk("lat_post", {out_valid, out_sel, out_data}, {1'b1, 1'b0, 16'h1234});
      wait_drain("drain_t1", 50);
      chk("t1_cnt1", cnt1, 16'd1);
      chk("t1_cnt2", cnt2, 16'd0);

      // Both lanes contending after reset: strict alternation starting with lane 1.
      reset_dut();
      out_ready = 1'b1;
      out_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         l1_q.push_back(16'h00A1 + 16'(i));
         l2_q.push_back(16'h00B1 + 16'(i));
         exp_q.push_back({1'b0, 16'h00A1 + 16'(i)});
         exp_q.push_back({1'b1, 16'h00B1 + 16'(i)});
      end
      wait_drain("drain_t2", 100);
      chk("t2_nout", out_cyc.size(), 8);
      if (out_cyc.size() == 8) chk("t2_nobubble", out_cyc[7] - out_cyc[0], 7);
      chk("t2_cnt1", cnt1, 16'd4);
      chk("t2_cnt2", cnt2, 16'd4);

      // Back-pressure: lane 1 fills the stage (lane 2 won last), stall 3 cycles, then resume.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         l1_q.push_back(16'h00C1 + 16'(i));
         l2_q.push_back(16'h00D1 + 16'(i));
         exp_q.push_back({1'b0, 16'h00C1 + 16'(i)});
         exp_q.push_back({1'b1, 16'h00D1 + 16'(i)});
      end
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("stall_fill", out_valid, 1);
      for (int i = 0; i < 3; i++) begin
         chk("stall_word", {out_valid, out_sel, out_data}, {1'b1, 1'b0, 16'h00C1});
         chk("stall_rdy", {in1_ready, in2_ready}, 2'b00);
         tick();
      end
      out_ready = 1'b1;
      wait_drain("drain_t3", 100);
      chk("t3_cnts", {cnt1, cnt2}, {16'd7, 16'd7});

      // Zero word on lane 2.
      reset_dut();
      out_ready = 1'b1;
      l2_q.push_back(16'h0000);
      l2_q.push_back(16'h0055);
`ifdef ZERO_SKIP_EN
      exp_q.push_back({1'b1, 16'h0055});
`else
      exp_q.push_back({1'b1, 16'h0000});
      exp_q.push_back({1'b1, 16'h0055});
`endif
      wait_drain("drain_t4", 50);
`ifdef ZERO_SKIP_EN
      chk("zs_cnt2", cnt2, 16'd1);
      chk("zs_skip", skip_cnt, 16'd1);
`else
      chk("zs_cnt2", cnt2, 16'd2);
      chk("zs_skip", skip_cnt, 16'd0);
`endif
      chk("zs_cnt1", cnt1, 16'd0);

      // Reset while a word is held: output discarded, lane 1 priority restored.
      out_ready = 1'b0;
      l1_q.push_back(16'h0777);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("t5_full", {out_valid, out_data}, {1'b1, 16'h0777});
      @(posedge clk);
      #3;
      reset = 1'b1;
      flush();
      #1;
      chk("t5_async_v", out_valid, 0);
      chk("t5_cnts", {cnt1, cnt2, skip_cnt}, 48'd0);
      repeat (2) tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      l1_q.push_back(16'h00E1);
      l2_q.push_back(16'h00F1);
      exp_q.push_back({1'b0, 16'h00E1});
      exp_q.push_back({1'b1, 16'h00F1});
      wait_drain("drain_t5", 50);

      // Counter saturation on lane 1.
      reset_dut();
      verbose   = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i <= 65535; i++) begin
         l1_q.push_back(16'(i));
         exp_q.push_back({1'b0, 16'(i)});
      end
      wait_drain("drain_sat", 70000);
      verbose = 1'b1;
      chk("sat_cnt1", cnt1, 16'hFFFF);
      l1_q.push_back(16'h4321);
      exp_q.push_back({1'b0, 16'h4321});
      wait_drain("drain_sat1", 50);
      chk("sat_hold", cnt1, 16'hFFFF);
      chk("sat_cnt2", cnt2, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
